// File: rtl/my_16encoder_pkg.sv
// Shared definitions for the 16-line request encoder.
package my_defs;

  localparam int unsigned ENC_W = 4;
  localparam int unsigned N_REQ = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // One-hot decode of an encoded request index.
  function automatic logic [N_REQ-1:0] idx2onehot(input logic [ENC_W-1:0] idx);
    logic [N_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/my_16encoder_prio_pick.sv
// Combinational find-first-set over the eligible lines, starting at 'start'
// and wrapping from 15 back to 0.
module my_prio_pick
  import my_defs::*;
(
  input  logic [N_REQ-1:0] elig,
  input  logic [ENC_W-1:0] start,
  output logic             any,
  output logic [ENC_W-1:0] sel
);

  logic [ENC_W-1:0] idx;

  // Walk the lines in rotated order; the first eligible one found is kept.
  always_comb begin
    any = 1'b0;
    sel = '0;
    idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = start + ENC_W'(i);
      if (!any && elig[idx]) begin
        any = 1'b1;
        sel = idx;
      end
    end
  end

endmodule

// File: rtl/my_16encoder.sv
// 16-to-4 request encoder: edge-captured sticky pending bits, a priority
// picker (fixed or rotating) and a registered index with a valid/ack handshake.
module my_16encoder
  import my_defs::*;
#(
  parameter int unsigned ROUND_ROBIN = 0,
  parameter int unsigned N_REQ       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] mask,
  input  logic             ack,
  output logic             valid,
  output logic [ENC_W-1:0] index,
  output logic [N_REQ-1:0] onehot,
  output logic [N_REQ-1:0] pending
);

  state_e           state_q;
  logic             valid_q;
  logic [ENC_W-1:0] index_q;
  logic [ENC_W-1:0] rr_ptr_q;
  logic [N_REQ-1:0] req_q;
  logic [N_REQ-1:0] pending_q, pending_d;

  logic [N_REQ-1:0] rise;
  logic [N_REQ-1:0] clr;
  logic [N_REQ-1:0] elig;
  logic [ENC_W-1:0] start;
  logic             pick_any;
  logic [ENC_W-1:0] pick_sel;
  logic             ack_take;

  // Edge detect, handshake clear and eligibility; a new edge beats a same-cycle clear.
  always_comb begin
    rise      = req & ~req_q;
    ack_take  = (state_q == GRANT) && ack;
    clr       = ack_take ? idx2onehot(index_q) : '0;
    pending_d = (pending_q & ~clr) | rise;
    elig      = pending_q & ~mask;
    start     = (ROUND_ROBIN != 0) ? rr_ptr_q : '0;
  end

  my_prio_pick u_pick (
    .elig  (elig),
    .start (start),
    .any   (pick_any),
    .sel   (pick_sel)
  );

  // Request history and sticky pending register; history resets high so
  // lines already asserted at reset release do not count as edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_q     <= '1;
      pending_q <= '0;
    end else begin
      req_q     <= req;
      pending_q <= pending_d;
    end
  end

  // Grant FSM with registered valid/index and rotating-priority pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      valid_q  <= 1'b0;
      index_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            index_q <= pick_sel;
            valid_q <= 1'b1;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (ack) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
            if (ROUND_ROBIN != 0) begin
              rr_ptr_q <= index_q + 4'd1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign valid   = valid_q;
  assign index   = index_q;
  assign onehot  = valid_q ? idx2onehot(index_q) : '0;
  assign pending = pending_q;

endmodule
